writeback_arbiter: RTL and testbench

//  Shares the single register-file write port between the execute result stream and the

---
 rtl/writeback_arbiter_pkg.sv | 27 ++
 rtl/writeback_arbiter_if.sv | 49 ++++
 rtl/writeback_arbiter_queue.sv | 91 +++++++++
 rtl/writeback_arbiter.sv | 128 ++++++++++++
 tb/tb_writeback_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// writeback_arbiter_pkg
//   Shared widths and the holding-queue entry type for the writeback arbiter.
//   The XLEN and REG_ADDR_W constants must match the exec and dmem interfaces.
//   Contents:
//     XLEN        data / PC width
//     REG_ADDR_W  register index width
//     wb_entry_t  {valid, rd, value} queued exec result
//     rd_writes() true when a destination index names a writable register
// ---------------------------------------------------------------------------
package writeback_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       value;
  } wb_entry_t;

  // x0 is hard-wired zero, so a write to it is never performed.
  function automatic logic rd_writes(input logic [REG_ADDR_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// ---------------------------------------------------------------------------
// writeback_arbiter_if
//   Bundles the exec result stream, the load result stream and the
//   register-file / PC write outputs of the writeback arbiter.
//   Modports:
//     slave   the arbiter: consumes exec/load, drives exec_ready, wb_*, pc_*
//     master  the surrounding pipeline: drives exec/load, observes the rest
// ---------------------------------------------------------------------------
interface writeback_arbiter_if;
  import writeback_arbiter_pkg::*;

  // exec result stream
  logic                  exec_valid;
  logic [REG_ADDR_W-1:0] exec_rd;
  logic [XLEN-1:0]       exec_rd_value;
  logic [XLEN-1:0]       exec_pc;
  logic                  exec_ready;

  // load result stream (never backpressured)
  logic                  load_valid;
  logic [REG_ADDR_W-1:0] load_rd;
  logic [XLEN-1:0]       load_rd_value;

  // register-file write port
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_rd_value;

  // PC register update
  logic                  pc_valid;
  logic [XLEN-1:0]       pc_value;

  modport slave (
    input  exec_valid, exec_rd, exec_rd_value, exec_pc,
    output exec_ready,
    input  load_valid, load_rd, load_rd_value,
    output wb_valid, wb_rd, wb_rd_value,
    output pc_valid, pc_value
  );

  modport master (
    output exec_valid, exec_rd, exec_rd_value, exec_pc,
    input  exec_ready,
    output load_valid, load_rd, load_rd_value,
    input  wb_valid, wb_rd, wb_rd_value,
    input  pc_valid, pc_value
  );

endinterface

// File: rtl/writeback_arbiter_queue.sv
// ---------------------------------------------------------------------------
// writeback_arbiter_queue
//   QDEPTH-entry in-order circular FIFO of wb_entry_t holding exec results
//   that lost the write port. Pointers wrap modulo QDEPTH, so any depth >= 1
//   works. kill_en/kill_rd clear the valid bit of every stored entry whose rd
//   matches; killed entries keep their slot until popped.
//   Ports:
//     clk, rst_n          clock, async active-low reset
//     push, push_entry    enqueue (caller guarantees !full)
//     pop                 dequeue head (caller guarantees !empty)
//     kill_en, kill_rd    invalidate stored entries targeting kill_rd
//     head                current head entry
//     full, empty, count  occupancy (registered)
// ---------------------------------------------------------------------------
module writeback_arbiter_queue
  import writeback_arbiter_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  wb_entry_t                     push_entry,
  input  logic                          pop,
  input  logic                          kill_en,
  input  logic [REG_ADDR_W-1:0]         kill_rd,
  output wb_entry_t                     head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(QDEPTH+1)-1:0]   count
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  wb_entry_t          mem_q [QDEPTH];
  wb_entry_t          mem_d [QDEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      mem_d[i] = mem_q[i];
      // Only entries already stored are older than the killing load.
      if (kill_en && mem_q[i].rd == kill_rd) begin
        mem_d[i].valid = 1'b0;
      end
    end
    // The pushed entry lands after the kill so a same-cycle push survives.
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
    end

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(QDEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/writeback_arbiter.sv
// ---------------------------------------------------------------------------
// writeback_arbiter
//   Shares the single register-file write port between exec results and
//   load data. Loads win outright; exec results that cannot write now wait
//   in an in-order holding queue, and exec is stalled when that queue is
//   full. A load also invalidates older queued writes to the same register.
//   All wb_* / pc_* outputs are registered (one cycle after acceptance).
//   Ports:
//     clk, rst_n    clock, async active-low reset
//     bus           writeback_arbiter_if.slave (exec, load, wb, pc signals)
//     q_count       holding-queue occupancy
//     stall_cycles  saturating count of cycles exec was held off
// ---------------------------------------------------------------------------
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int QDEPTH  = 2,
  parameter int STALL_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  writeback_arbiter_if.slave           bus,
  output logic [$clog2(QDEPTH+1)-1:0]  q_count,
  output logic [STALL_W-1:0]           stall_cycles
);

  wb_entry_t              q_head;
  wb_entry_t              q_push_entry;
  logic                   q_full, q_empty;
  logic                   q_push, q_pop;
  logic                   exec_acc, exec_wr, load_win, bypass;

  logic                   wb_valid_q, wb_valid_d;
  logic [REG_ADDR_W-1:0]  wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]        wb_rd_value_q, wb_rd_value_d;
  logic                   pc_valid_q, pc_valid_d;
  logic [XLEN-1:0]        pc_value_q, pc_value_d;
  logic [STALL_W-1:0]     stall_cycles_q, stall_cycles_d;

  writeback_arbiter_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (q_push),
    .push_entry (q_push_entry),
    .pop        (q_pop),
    .kill_en    (load_win),
    .kill_rd    (bus.load_rd),
    .head       (q_head),
    .full       (q_full),
    .empty      (q_empty),
    .count      (q_count)
  );

  always_comb begin
    // Ready comes from the registered count: a pop this cycle frees its
    // slot only for next cycle's exec.
    exec_acc = bus.exec_valid && !q_full;
    exec_wr  = exec_acc && rd_writes(bus.exec_rd);
    load_win = bus.load_valid && rd_writes(bus.load_rd);
    // Bypass only with an empty queue, so exec never overtakes older work;
    // a popped (even cancelled) head also blocks the bypass.
    bypass   = exec_wr && !load_win && q_empty;
    q_push   = exec_wr && !bypass;
    q_pop    = !load_win && !q_empty;

    q_push_entry.valid = 1'b1;
    q_push_entry.rd    = bus.exec_rd;
    q_push_entry.value = bus.exec_rd_value;

    wb_valid_d    = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_rd_value_d = wb_rd_value_q;
    if (load_win) begin
      wb_valid_d    = 1'b1;
      wb_rd_d       = bus.load_rd;
      wb_rd_value_d = bus.load_rd_value;
    end else if (!q_empty) begin
      // A cancelled head is retired silently.
      wb_valid_d = q_head.valid;
      if (q_head.valid) begin
        wb_rd_d       = q_head.rd;
        wb_rd_value_d = q_head.value;
      end
    end else if (bypass) begin
      wb_valid_d    = 1'b1;
      wb_rd_d       = bus.exec_rd;
      wb_rd_value_d = bus.exec_rd_value;
    end

    // PC follows every accepted exec, including rd==0 results.
    pc_valid_d = exec_acc;
    pc_value_d = exec_acc ? bus.exec_pc : pc_value_q;

    stall_cycles_d = stall_cycles_q;
    if (bus.exec_valid && q_full && stall_cycles_q != '1) begin
      stall_cycles_d = stall_cycles_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_rd_value_q  <= '0;
      pc_valid_q     <= 1'b0;
      pc_value_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_rd_value_q  <= wb_rd_value_d;
      pc_valid_q     <= pc_valid_d;
      pc_value_q     <= pc_value_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.exec_ready  = !q_full;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_rd_value = wb_rd_value_q;
  assign bus.pc_valid    = pc_valid_q;
  assign bus.pc_value    = pc_value_q;
  assign stall_cycles    = stall_cycles_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_writeback_arbiter
//   Directed scenarios followed by random traffic, all checked against a
//   queue-based reference model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_writeback_arbiter;

  localparam int QD   = 2;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic                    clk;
  logic                    rst_n;
  logic [$clog2(QD+1)-1:0] q_count;
  logic [SW-1:0]           stall_cycles;

  writeback_arbiter_if wb_if ();

  writeback_arbiter #(
    .QDEPTH  (QD),
    .STALL_W (SW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (wb_if),
    .q_count      (q_count),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int n_txn   = 0;

  // Reference model: pending exec writes, oldest first.
  typedef struct {
    bit          v;
    logic [4:0]  rd;
    logic [31:0] val;
  } ent_t;

  ent_t        mq[$];
  bit          m_wbv;
  logic [4:0]  m_wb_rd;
  logic [31:0] m_wb_val;
  bit          m_pcv;
  logic [31:0] m_pc_val;
  int          m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_wbv    = 0;
    m_wb_rd  = '0;
    m_wb_val = '0;
    m_pcv    = 0;
    m_pc_val = '0;
    m_stall  = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_wbv"}, 32'(wb_if.wb_valid), 32'(m_wbv));
    if (m_wbv) begin
      chk({tag, "_rd"},  32'(wb_if.wb_rd), 32'(m_wb_rd));
      chk({tag, "_val"}, wb_if.wb_rd_value, m_wb_val);
    end
    chk({tag, "_pcv"}, 32'(wb_if.pc_valid), 32'(m_pcv));
    if (m_pcv) chk({tag, "_pc"}, wb_if.pc_value, m_pc_val);
    chk({tag, "_rdy"},   32'(wb_if.exec_ready), 32'(mq.size() != QD));
    chk({tag, "_cnt"},   32'(q_count), 32'(mq.size()));
    chk({tag, "_stall"}, 32'(stall_cycles), 32'(m_stall));
  endtask

  // Called at a negedge: drive one cycle of inputs, advance the model,
  // then compare the registered outputs at the following negedge.
  task automatic step(input bit ev, input logic [4:0] erd, input logic [31:0] eval,
                      input logic [31:0] epc, input bit lv, input logic [4:0] lrd,
                      input logic [31:0] lval, input string tag);
    bit ready, acc, lw, exec_w, wrote;
    ent_t h;
    wb_if.exec_valid    = ev;
    wb_if.exec_rd       = erd;
    wb_if.exec_rd_value = eval;
    wb_if.exec_pc       = epc;
    wb_if.load_valid    = lv;
    wb_if.load_rd       = lrd;
    wb_if.load_rd_value = lval;

    ready  = (mq.size() != QD);
    acc    = ev && ready;
    exec_w = acc && (erd != 0);
    lw     = lv && (lrd != 0);
    if (ev && !ready && m_stall != SMAX) m_stall++;

    wrote = 0;
    m_wbv = 0;
    if (lw) begin
      foreach (mq[i]) if (mq[i].rd == lrd) mq[i].v = 0;
      m_wbv = 1; m_wb_rd = lrd; m_wb_val = lval;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      if (h.v) begin
        m_wbv = 1; m_wb_rd = h.rd; m_wb_val = h.val;
      end
    end else if (exec_w) begin
      m_wbv = 1; m_wb_rd = erd; m_wb_val = eval;
      wrote = 1;
    end
    if (exec_w && !wrote) mq.push_back('{v: 1, rd: erd, val: eval});
    m_pcv = acc;
    if (acc) m_pc_val = epc;

    @(posedge clk);
    @(negedge clk);
    n_txn++;
    check_outputs(tag);
    $display("txn %0d %s ev=%0d erd=%0d lv=%0d lrd=%0d -> wbv=%0d rd=%0d val=%0h cnt=%0d",
             n_txn, tag, ev, erd, lv, lrd, wb_if.wb_valid, wb_if.wb_rd,
             wb_if.wb_rd_value, q_count);
  endtask

  task automatic idle(input string tag);
    step(0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0, tag);
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_wbv"},   32'(wb_if.wb_valid), 32'h0);
    chk({tag, "_rd"},    32'(wb_if.wb_rd), 32'h0);
    chk({tag, "_val"},   wb_if.wb_rd_value, 32'h0);
    chk({tag, "_pcv"},   32'(wb_if.pc_valid), 32'h0);
    chk({tag, "_pc"},    wb_if.pc_value, 32'h0);
    chk({tag, "_cnt"},   32'(q_count), 32'h0);
    chk({tag, "_rdy"},   32'(wb_if.exec_ready), 32'h1);
    chk({tag, "_stall"}, 32'(stall_cycles), 32'h0);
  endtask

  initial begin
    rst_n               = 1'b0;
    wb_if.exec_valid    = 1'b0;
    wb_if.exec_rd       = '0;
    wb_if.exec_rd_value = '0;
    wb_if.exec_pc       = '0;
    wb_if.load_valid    = 1'b0;
    wb_if.load_rd       = '0;
    wb_if.load_rd_value = '0;
    model_reset();

    repeat (2) @(negedge clk);
    check_reset_zero("rst");
    rst_n = 1'b1;

    // 1: lone exec bypasses straight to the write port
    step(1, 5'd5, 32'h11, 32'h4, 0, 5'd0, 32'h0, "t1");
    chk("t1_rd5", 32'(wb_if.wb_rd), 32'd5);
    chk("t1_v11", wb_if.wb_rd_value, 32'h11);
    idle("t1_idle");

    // 2: load wins, exec waits one cycle in the queue
    step(1, 5'd4, 32'hBB, 32'h8, 1, 5'd3, 32'hAA, "t2a");
    chk("t2_x3", wb_if.wb_rd_value, 32'hAA);
    chk("t2_cnt1", 32'(q_count), 32'd1);
    idle("t2b");
    chk("t2_x4", wb_if.wb_rd_value, 32'hBB);
    chk("t2_cnt0", 32'(q_count), 32'd0);

    // 3: four back-to-back loads with exec held valid
    for (int i = 0; i < 4; i++)
      step(1, 5'(8 + i), 32'(32'h100 + i), 32'(32'h200 + 4 * i), 1, 5'(1 + i),
           32'(32'h50 + i), "t3");
    chk("t3_stall", 32'(stall_cycles), 32'd2);
    chk("t3_rdy", 32'(wb_if.exec_ready), 32'd0);
    idle("t3_d1");
    chk("t3_first", 32'(wb_if.wb_rd), 32'd8);
    idle("t3_d2");
    chk("t3_second", 32'(wb_if.wb_rd), 32'd9);
    idle("t3_d3");

    // 4: load to rd 7 cancels the queued rd 7 write
    step(1, 5'd7, 32'h1, 32'h10, 1, 5'd1, 32'h77, "t4a");
    step(0, 5'd0, 32'h0, 32'h0, 1, 5'd7, 32'h2, "t4b");
    chk("t4_x7", wb_if.wb_rd_value, 32'h2);
    idle("t4c");
    chk("t4_silent", 32'(wb_if.wb_valid), 32'd0);
    idle("t4d");

    // 5: rd 0 on both streams
    step(1, 5'd0, 32'hDEAD, 32'h100, 0, 5'd0, 32'h0, "t5a");
    chk("t5_nowr", 32'(wb_if.wb_valid), 32'd0);
    chk("t5_pc", wb_if.pc_value, 32'h100);
    step(0, 5'd0, 32'h0, 32'h0, 1, 5'd0, 32'h33, "t5b");
    chk("t5_ld0", 32'(wb_if.wb_valid), 32'd0);

    // 6: reset with a full queue and a write in flight
    step(1, 5'd2, 32'h22, 32'h14, 1, 5'd1, 32'h21, "t6a");
    step(1, 5'd4, 32'h44, 32'h18, 1, 5'd3, 32'h43, "t6b");
    #1 rst_n = 1'b0;
    wb_if.exec_valid = 1'b0;
    wb_if.load_valid = 1'b0;
    #1 check_reset_zero("t6_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle("t6_rel1");
    chk("t6_nostale", 32'(wb_if.wb_valid), 32'd0);
    idle("t6_rel2");

    // Random traffic with small rd range for frequent collisions and zeros
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), $urandom, $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom, "rnd");
    end
    for (int n = 0; n < 4; n++) idle("drain");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
